// File: rtl/axi_rr_arbiter.sv
// N-master round-robin arbiter with optional burst lock (hold grant until LAST)
// feeding a single-entry valid/ready output register.
module axi_rr_arbiter #(
  parameter int N         = 2,
  parameter int DW        = 49,
  parameter int LOCK_LAST = 0,
  parameter int LAST_BIT  = 0,
  parameter int SW        = $clog2(N)
) (
  input  logic            AXI_CLK_i,
  input  logic            AXI_RST_i,
  input  logic [N-1:0]    in_valid_i,
  input  logic [N*DW-1:0] in_data_i,
  output logic [N-1:0]    in_ready_o,
  output logic            out_valid_o,
  output logic [DW-1:0]   out_data_o,
  output logic [SW-1:0]   out_sel_o,
  input  logic            out_ready_i,
  output logic            lock_o
);

  localparam bit LOCK_EN = LOCK_LAST[0];

  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic [SW-1:0] out_sel_r;
  logic [SW-1:0] ptr_r;
  logic [SW-1:0] lock_idx_r;
  logic          lock_r;

  logic          load_s;
  logic [N-1:0]  cand_s;
  logic          hi_found_s;
  logic          lo_found_s;
  logic [SW-1:0] hi_idx_s;
  logic [SW-1:0] lo_idx_s;
  logic          gnt_found_s;
  logic [SW-1:0] gnt_idx_s;
  logic [DW-1:0] gnt_data_s;
  logic          xfer_s;
  logic [SW-1:0] ptr_next_s;

  assign load_s = ~out_valid_r | out_ready_i;

  // Rotating-priority search: lowest candidate at or above ptr_r, else lowest overall.
  always_comb begin
    cand_s     = '0;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s[k]  = in_valid_i[k] & (~lock_r | (lock_idx_r == SW'(k)));
      lo_found_s = lo_found_s | cand_s[k];
      lo_idx_s   = cand_s[k] ? SW'(k) : lo_idx_s;
      hi_found_s = hi_found_s | (cand_s[k] & (k >= int'(ptr_r)));
      hi_idx_s   = (cand_s[k] & (k >= int'(ptr_r))) ? SW'(k) : hi_idx_s;
    end
    gnt_found_s = lo_found_s;
    gnt_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Payload mux for the granted master and the per-master ready decode.
  always_comb begin
    gnt_data_s = '0;
    in_ready_o = '0;
    xfer_s     = ~AXI_RST_i & load_s & gnt_found_s;
    for (int k = 0; k < N; k++) begin
      gnt_data_s    = (gnt_idx_s == SW'(k)) ? in_data_i[k*DW +: DW] : gnt_data_s;
      in_ready_o[k] = xfer_s & (gnt_idx_s == SW'(k));
    end
    ptr_next_s = (gnt_idx_s == SW'(N - 1)) ? '0 : (gnt_idx_s + SW'(1));
  end

  // Output slice, rotation pointer and burst-lock state.
  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
      lock_r      <= 1'b0;
      lock_idx_r  <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= gnt_data_s;
      out_sel_r   <= gnt_idx_s;
      ptr_r       <= ptr_next_s;
      if (LOCK_EN) begin
        lock_r     <= ~gnt_data_s[LAST_BIT];
        lock_idx_r <= gnt_idx_s;
      end else begin
        lock_r     <= 1'b0;
        lock_idx_r <= '0;
      end
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign out_sel_o   = out_sel_r;
  assign lock_o      = lock_r;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: a 4-master locking instance and a 3-master
// non-locking instance checked every cycle against a queue-free search model.
module tb_axi_rr_arbiter;

  localparam int NA = 4;
  localparam int NB = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NA-1:0]    a_valid, a_ready;
  logic [NA*DW-1:0] a_data;
  logic             a_ovalid, a_ordy, a_lock;
  logic [DW-1:0]    a_odata;
  logic [1:0]       a_sel;

  logic [NB-1:0]    b_valid, b_ready;
  logic [NB*DW-1:0] b_data;
  logic             b_ovalid, b_ordy, b_lock;
  logic [DW-1:0]    b_odata;
  logic [1:0]       b_sel;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;
  bit mdl_on = 1'b0;

  bit         m_valid[2];
  logic [7:0] m_data[2];
  int         m_sel[2];
  bit         m_lock[2];
  int         m_lidx[2];
  int         m_ptr[2];

  axi_rr_arbiter #(.N(NA), .DW(DW), .LOCK_LAST(1), .LAST_BIT(0)) u_a (
    .AXI_CLK_i(clk), .AXI_RST_i(rst),
    .in_valid_i(a_valid), .in_data_i(a_data), .in_ready_o(a_ready),
    .out_valid_o(a_ovalid), .out_data_o(a_odata), .out_sel_o(a_sel),
    .out_ready_i(a_ordy), .lock_o(a_lock)
  );

  axi_rr_arbiter #(.N(NB), .DW(DW), .LOCK_LAST(0), .LAST_BIT(3)) u_b (
    .AXI_CLK_i(clk), .AXI_RST_i(rst),
    .in_valid_i(b_valid), .in_data_i(b_data), .in_ready_o(b_ready),
    .out_valid_o(b_ovalid), .out_data_o(b_odata), .out_sel_o(b_sel),
    .out_ready_i(b_ordy), .lock_o(b_lock)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference: scan masters from ptr with modular index, first eligible wins.
  task automatic model_cmp(int u, int n, bit lock_en, int last_bit,
                           logic [15:0] vld, logic [127:0] dat, bit ordy, bit r,
                           logic [15:0] act_rdy, logic act_v, logic [7:0] act_d,
                           logic [1:0] act_sel, logic act_lock);
    bit          load;
    int          grant;
    logic [15:0] exp_rdy;
    logic [7:0]  pay;
    string       p;
    p     = (u == 0) ? "A" : "B";
    load  = !m_valid[u] || ordy;
    grant = -1;
    for (int off = 0; off < n; off++) begin
      int k;
      k = (m_ptr[u] + off) % n;
      if (grant < 0 && vld[k] && (!m_lock[u] || k == m_lidx[u])) grant = k;
    end
    exp_rdy = '0;
    if (!r && load && grant >= 0) exp_rdy[grant] = 1'b1;
    if (mdl_on) begin
      check({p, ".in_ready"},  32'(act_rdy),  32'(exp_rdy));
      check({p, ".out_valid"}, 32'(act_v),    32'(m_valid[u]));
      check({p, ".out_data"},  32'(act_d),    32'(m_data[u]));
      check({p, ".out_sel"},   32'(act_sel),  32'(m_sel[u]));
      check({p, ".lock"},      32'(act_lock), 32'(m_lock[u]));
    end
    if (r) begin
      m_valid[u] = 1'b0; m_data[u] = 8'h00; m_sel[u] = 0;
      m_lock[u]  = 1'b0; m_lidx[u] = 0;     m_ptr[u] = 0;
    end else if (exp_rdy != 16'h0000) begin
      pay        = dat[grant*8 +: 8];
      m_valid[u] = 1'b1;
      m_data[u]  = pay;
      m_sel[u]   = grant;
      m_ptr[u]   = (grant + 1) % n;
      m_lock[u]  = lock_en ? !pay[last_bit] : 1'b0;
      m_lidx[u]  = grant;
    end else if (ordy) begin
      m_valid[u] = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    model_cmp(0, NA, 1'b1, 0, 16'(a_valid), 128'(a_data), a_ordy, rst,
              16'(a_ready), a_ovalid, a_odata, a_sel, a_lock);
    model_cmp(1, NB, 1'b0, 3, 16'(b_valid), 128'(b_data), b_ordy, rst,
              16'(b_ready), b_ovalid, b_odata, b_sel, b_lock);
    if (rst) mdl_on = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(string nm, int sel_e[4], int rdy_e[4]);
    for (int i = 0; i < 4; i++) begin
      #1 check({nm, ".ready"}, 32'(a_ready), 32'(rdy_e[i]));
      cyc();
      check({nm, ".sel"},   32'(a_sel),    32'(sel_e[i]));
      check({nm, ".data"},  32'(a_odata),  32'(sel_e[i] * 16 + 1));
      check({nm, ".valid"}, 32'(a_ovalid), 32'h1);
    end
  endtask

  // Stimulus for instance B: free-running random traffic.
  initial begin
    b_valid = '0;
    b_data  = '0;
    b_ordy  = 1'b1;
    while (!done) begin
      cyc();
      b_valid = 3'($urandom);
      b_data  = 24'($urandom);
      b_ordy  = ($urandom_range(0, 3) != 0);
    end
  end

  // Directed scenarios on instance A, then random traffic.
  initial begin
    logic [7:0] beats [4];
    beats = '{8'h02, 8'h04, 8'h06, 8'h07};
    a_valid = '0;
    a_data  = {8'h31, 8'h21, 8'h11, 8'h01};
    a_ordy  = 1'b1;
    rst     = 1'b1;
    cyc();
    a_valid = 4'hf;
    cyc();
    #1;
    check("rst.ready", 32'(a_ready),  32'h0);
    check("rst.valid", 32'(a_ovalid), 32'h0);
    check("rst.data",  32'(a_odata),  32'h0);
    check("rst.sel",   32'(a_sel),    32'h0);
    check("rst.lock",  32'(a_lock),   32'h0);

    // Two masters alternate at full rate.
    rst = 1'b0;
    a_valid = 4'b0011;
    run_seq("alt", '{0, 1, 0, 1}, '{1, 2, 1, 2});

    // Masters 1 and 3 from a fresh pointer.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_valid = 4'b1010;
    run_seq("m13", '{1, 3, 1, 3}, '{2, 8, 2, 8});

    // Five stall cycles, then release with same-cycle reload.
    a_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp.ready", 32'(a_ready), 32'h0);
      cyc();
      check("bp.data", 32'(a_odata), 32'h31);
      check("bp.sel",  32'(a_sel),   32'h3);
    end
    a_ordy = 1'b1;
    #1 check("bp.rel_ready", 32'(a_ready), 32'h2);
    cyc();
    check("bp.rel_sel",  32'(a_sel),   32'h1);
    check("bp.rel_data", 32'(a_odata), 32'h11);

    // Four-beat locked burst from master 0 with master 1 waiting.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_valid = 4'b0011;
    for (int b = 0; b < 4; b++) begin
      a_data[7:0] = beats[b];
      #1 check("lk.ready", 32'(a_ready), 32'h1);
      cyc();
      check("lk.sel",  32'(a_sel),   32'h0);
      check("lk.data", 32'(a_odata), 32'(beats[b]));
      check("lk.lock", 32'(a_lock),  (b < 3) ? 32'h1 : 32'h0);
    end
    a_data[7:0] = 8'h08;
    #1 check("lk.next_ready", 32'(a_ready), 32'h2);
    cyc();
    check("lk.next_sel", 32'(a_sel), 32'h1);

    // Master 0 locks again, then idles while master 1 waits.
    #1 check("idle.ready0", 32'(a_ready), 32'h1);
    cyc();
    check("idle.lock0", 32'(a_lock), 32'h1);
    a_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 check("idle.ready", 32'(a_ready), 32'h0);
      cyc();
      check("idle.valid", 32'(a_ovalid), 32'h0);
      check("idle.lock",  32'(a_lock),   32'h1);
    end

    // Reset in the middle of a locked burst with a beat held.
    a_valid = 4'b0011;
    a_data[7:0] = 8'h0a;
    #1 check("mr.ready", 32'(a_ready), 32'h1);
    cyc();
    check("mr.valid_pre", 32'(a_ovalid), 32'h1);
    rst = 1'b1;
    #1 check("mr.ready_rst", 32'(a_ready), 32'h0);
    cyc();
    check("mr.valid", 32'(a_ovalid), 32'h0);
    check("mr.lock",  32'(a_lock),   32'h0);
    check("mr.data",  32'(a_odata),  32'h0);
    rst = 1'b0;
    a_valid = 4'b0110;
    #1 check("mr.first_ready", 32'(a_ready), 32'h2);
    cyc();
    check("mr.first_sel", 32'(a_sel), 32'h1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      a_valid = 4'($urandom);
      a_data  = $urandom;
      a_ordy  = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();
    done = 1'b1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Parametrised N-master round-robin arbiter with a registered output stage, used per AXI request channel (AR, AW, W) in the master-side crossbar interface ahead of the clock-crossing FIFOs. Generalises the two-input fixed-priority arbiter to N masters, adds fair rotation and a burst-lock mode that holds the grant on one master until its last beat. Output is a single-entry valid/ready register slice, so the downstream FIFO's full flag never feeds back combinationally into the master ports.

## Interface
- N, 2, number of masters; legal range 2..16.
- DW, 49, payload width per master; 49 for AR/AW, 37 for W.
- LOCK_LAST, 0, 1 = hold grant on a master until a beat with payload bit LAST_BIT = 1 transfers; 0 = re-arbitrate every beat.
- LAST_BIT, 0, payload bit index carrying WLAST; used only when LOCK_LAST = 1.
- SW, $clog2(N), width of the master index.

- AXI_CLK_i  input  1  clock; all logic on the rising edge.
- AXI_RST_i  input  1  reset; synchronous, active-high.
- in_valid_i  input  N  per-master request valid.
- in_data_i  input  N*DW  master k payload at bits [k*DW +: DW].
- in_ready_o  output  N  one-hot or zero; master k's beat transfers when in_valid_i[k] & in_ready_o[k].
- out_valid_o  output  1  output register holds a beat.
- out_data_o  output  DW  registered payload.
- out_sel_o  output  SW  registered index of the master whose beat is in out_data_o.
- out_ready_i  input  1  downstream accepts (driven as valid & ~wfull by the FIFO side).
- lock_o  output  1  registered; a burst lock is active.

## Operation
- load = ~out_valid_o | out_ready_i (register empty or draining this cycle).
- Candidate set: if lock_o, only master lock_idx; else all masters with in_valid_i set.
- Round-robin: search starts at ptr, ascending index, wrapping N-1 -> 0; first candidate wins -> gnt_idx. No candidate -> no grant.
- in_ready_o[gnt_idx] = load; all other bits 0. Combinational from in_valid_i, ptr, lock state, out_valid_o, out_ready_i.
- On transfer from master k: out_data_o <= that payload, out_sel_o <= k, out_valid_o <= 1, ptr <= (k+1) mod N.
- Lock (LOCK_LAST = 1 only): transfer with payload[LAST_BIT] = 0 -> lock_o <= 1, lock_idx <= k; transfer with payload[LAST_BIT] = 1 -> lock_o <= 0. While locked, other masters' in_ready_o remain 0 even if the locked master idles.
- LOCK_LAST = 0: lock_o stuck at 0, LAST_BIT ignored.
- Drain with no new grant (out_ready_i = 1, no candidate): out_valid_o <= 0; out_data_o and out_sel_o hold last values.
- Stall (out_valid_o = 1, out_ready_i = 0): out_data_o, out_sel_o, ptr, lock state hold; all in_ready_o = 0.
- Drain and reload in the same cycle is allowed: sustained throughput one beat per cycle.

## Timing
- Reset values: out_valid_o = 0, out_data_o = 0, out_sel_o = 0, lock_o = 0, lock_idx = 0, ptr = 0 (master 0 first). in_ready_o follows combinationally: all zero unless a master is valid during reset deassertion cycle; during AXI_RST_i = 1 in_ready_o is forced to 0.
- Latency: beat accepted at edge t appears on out_data_o/out_valid_o after edge t, one cycle.
- Reset asserted mid-burst: lock cleared, any held beat discarded, ptr returns to 0 on the next edge.
- Single valid master: granted every load cycle regardless of ptr.
- ptr advances only on a transfer, never on idle cycles.

## Test plan
- N=2, LOCK_LAST=0: both valid every cycle, out_ready_i=1 -> out_sel_o sequence 0,1,0,1; one beat per cycle, in_ready_o alternates 01,10.
- N=4: masters 1 and 3 valid after reset, ptr=0 -> first grant 1, then 3, then 1; masters 0/2 never granted.
- Backpressure: out_valid_o=1, out_ready_i=0 for 5 cycles -> in_ready_o=0, out_data_o stable; release -> held beat leaves, next beat loads same cycle.
- LOCK_LAST=1, N=2, LAST_BIT=0: master 0 sends 4-beat burst (last on beat 4), master 1 valid throughout -> four consecutive out_sel_o=0, lock_o=1 after beats 1-3, master 1 granted on the cycle after beat 4.
- Locked master idles 3 cycles mid-burst while master 1 valid -> in_ready_o[1] stays 0, out_valid_o drops to 0.
- Assert AXI_RST_i during locked burst with out_valid_o=1 -> next cycle out_valid_o=0, lock_o=0, out_data_o=0; first post-reset grant goes to lowest valid index.
